// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for the ARM9TDMI fetch stage.
//
// Issues word-aligned requests over a single-outstanding req/ack handshake and
// buffers returned words in a QDEPTH-entry prefetch queue. The queue head goes to
// decode as IR/PC_OUT with FETCH_EN. A taken branch flushes the queue and redirects
// fetch. A request already on the bus is allowed to finish, and its data is dropped.
//
// Parameters:
//   RESET_VECTOR  first fetch address after reset (bits [1:0] ignored)
//   QDEPTH        prefetch queue entries, power of 2 in 2..8
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   IMEM_REQ/IMEM_ADDR      fetch request and word address (held until IMEM_ACK)
//   IMEM_ACK/IMEM_RDATA     request completion and returned instruction word
//   DEC_READY               decode consumes IR this cycle when FETCH_EN=1
//   FETCH_EN/IR/PC_OUT      queue head valid, instruction, and its address
//   BR_TAKEN/BR_TARGET      single-cycle redirect pulse and target address
//   STALL_CNT               decode-starved cycle counter (only with FETCH_PERF_CNT_EN)
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned QDEPTH       = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    input  logic        DEC_READY,
    output logic        FETCH_EN,
    output logic [31:0] IR,
    output logic [31:0] PC_OUT,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] STALL_CNT
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [31:0] RV_ALIGNED = RESET_VECTOR & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {StIdle, StReq, StHold, StFlush} state_e;

    state_e        state_q;
    logic [CW-1:0] count_q, count_d, left;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   tgt_q;
    logic [31:0]   mem_addr_q [QDEPTH];
    logic [31:0]   mem_data_q [QDEPTH];
    logic          push, pop;
    logic [31:0]   br_addr, head_pc_d, head_ir_d;

    always_comb begin
        // Data is only kept when acked in REQ; FLUSH and same-cycle branches drop it.
        push     = IMEM_ACK & (state_q == StReq) & ~BR_TAKEN;
        pop      = FETCH_EN & DEC_READY & ~BR_TAKEN;
        br_addr  = BR_TARGET & 32'hFFFF_FFFC;
        left     = count_q - CW'(pop);
        count_d  = BR_TAKEN ? '0 : left + CW'(push);
        rd_ptr_d = BR_TAKEN ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = BR_TAKEN ? '0 : wr_ptr_q + PW'(push);
        head_pc_d = '0;
        head_ir_d = '0;
        if (count_d != '0) begin
            if (left == '0) begin
                // Queue empties before the push: the incoming word becomes the head.
                head_pc_d = IMEM_ADDR;
                head_ir_d = IMEM_RDATA;
            end else begin
                head_pc_d = mem_addr_q[rd_ptr_d];
                head_ir_d = mem_data_q[rd_ptr_d];
            end
        end
    end

    // Queue storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= IMEM_ADDR;
            mem_data_q[wr_ptr_q] <= IMEM_RDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            IMEM_REQ  <= 1'b0;
            IMEM_ADDR <= RV_ALIGNED;
            tgt_q     <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            FETCH_EN  <= 1'b0;
            IR        <= '0;
            PC_OUT    <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            FETCH_EN <= (count_d != '0);
            IR       <= head_ir_d;
            PC_OUT   <= head_pc_d;
            unique case (state_q)
                StIdle: begin
                    if (BR_TAKEN) IMEM_ADDR <= br_addr;
                    state_q  <= StReq;
                    IMEM_REQ <= 1'b1;
                end
                StReq: begin
                    if (BR_TAKEN) begin
                        if (IMEM_ACK) begin
                            IMEM_ADDR <= br_addr;
                        end else begin
                            // Request cannot be withdrawn: finish it, then redirect.
                            tgt_q   <= br_addr;
                            state_q <= StFlush;
                        end
                    end else if (IMEM_ACK) begin
                        IMEM_ADDR <= IMEM_ADDR + 32'd4;
                        if (count_d == DEPTH_C) begin
                            state_q  <= StHold;
                            IMEM_REQ <= 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (BR_TAKEN) begin
                        IMEM_ADDR <= br_addr;
                        state_q   <= StReq;
                        IMEM_REQ  <= 1'b1;
                    end else if (count_q < DEPTH_C) begin
                        state_q  <= StReq;
                        IMEM_REQ <= 1'b1;
                    end
                end
                StFlush: begin
                    if (IMEM_ACK) begin
                        IMEM_ADDR <= BR_TAKEN ? br_addr : tgt_q;
                        state_q   <= StReq;
                    end else if (BR_TAKEN) begin
                        tgt_q <= br_addr;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            STALL_CNT <= '0;
        end else if (DEC_READY && !FETCH_EN && (STALL_CNT != 32'hFFFF_FFFF)) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif

endmodule
